// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of issue, writeback-request and regfile-write signals shared by the
// writeback arbiter and its clients.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int NREQ = 3
);
    logic                   iss_valid;
    logic [4:0]             iss_rd;
    logic [4:0]             iss_rs1;
    logic [4:0]             iss_rs2;
    logic                   iss_stall;

    logic [NREQ-1:0]        req_valid;
    logic [5*NREQ-1:0]      req_addr;
    logic [XLEN*NREQ-1:0]   req_data;
    logic [NREQ-1:0]        req_ready;

    logic                   rf_we;
    logic [4:0]             rf_waddr;
    logic [XLEN-1:0]        rf_wdata;
    logic [31:0]            busy_vec;
    logic                   wb_err;

    modport master (
        output iss_valid, iss_rd, iss_rs1, iss_rs2,
        output req_valid, req_addr, req_data,
        input  iss_stall, req_ready,
        input  rf_we, rf_waddr, rf_wdata, busy_vec, wb_err
    );

    modport slave (
        input  iss_valid, iss_rd, iss_rs1, iss_rs2,
        input  req_valid, req_addr, req_data,
        output iss_stall, req_ready,
        output rf_we, rf_waddr, rf_wdata, busy_vec, wb_err
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for three requesters driving one regfile write
// port, with a busy-register scoreboard that stalls issue on hazards.
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREQ = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);
    logic [1:0]      rr_ptr;
    logic [NREQ-1:0] grant;
    logic [1:0]      gnt_idx;
    logic [1:0]      idx;
    logic            found;
    logic            transfer;
    logic            issue_acc;
    logic            hazard;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic [31:0]     busy_q;
    logic [31:0]     busy_next;
    logic            rf_we_q;
    logic [4:0]      rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q;
    logic            wb_err_q;

    logic [4:0]      addr_arr [NREQ];
    logic [XLEN-1:0] data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g] = bus.req_addr[5*g +: 5];
        assign data_arr[g] = bus.req_data[XLEN*g +: XLEN];
    end

    function automatic logic [1:0] wrap(input int v);
        return 2'(v % NREQ);
    endfunction

    // First valid requester at or after rr_ptr wins; nothing is granted in reset.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        idx     = '0;
        found   = 1'b0;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = wrap(int'(rr_ptr) + k);
                if (!found && bus.req_valid[idx]) begin
                    grant[idx] = 1'b1;
                    gnt_idx    = idx;
                    found      = 1'b1;
                end
            end
        end
    end

    assign transfer = found;
    assign wb_addr  = addr_arr[gnt_idx];
    assign wb_data  = data_arr[gnt_idx];

    // Hazards are checked against the registered scoreboard, so a writeback
    // landing this edge does not release a stall until the next cycle.
    assign hazard = ((bus.iss_rs1 != 5'd0) && busy_q[bus.iss_rs1]) ||
                    ((bus.iss_rs2 != 5'd0) && busy_q[bus.iss_rs2]) ||
                    ((bus.iss_rd  != 5'd0) && busy_q[bus.iss_rd]);

    assign bus.iss_stall = !rst && bus.iss_valid && hazard;
    assign issue_acc     = !rst && bus.iss_valid && !hazard;

    // Clear before set so an issue and a writeback to the same register leave it busy.
    always_comb begin
        busy_next = busy_q;
        if (transfer && (wb_addr != 5'd0))
            busy_next[wb_addr] = 1'b0;
        if (issue_acc && (bus.iss_rd != 5'd0))
            busy_next[bus.iss_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            busy_q <= busy_next;
            if (transfer) begin
                rr_ptr     <= wrap(int'(gnt_idx) + 1);
                rf_we_q    <= (wb_addr != 5'd0);
                rf_waddr_q <= wb_addr;
                rf_wdata_q <= wb_data;
                if ((wb_addr != 5'd0) && !busy_q[wb_addr])
                    wb_err_q <= 1'b1;
            end else begin
                rf_we_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.busy_vec  = busy_q;
    assign bus.wb_err    = wb_err_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for the writeback arbiter and its issue scoreboard.
module tb_regfile_wb_arbiter;
    logic clk;
    logic rst;

    regfile_wb_arbiter_if #(.XLEN(32), .NREQ(3)) bus ();

    regfile_wb_arbiter #(.XLEN(32), .NREQ(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  valid;
        logic [14:0] addr;
        logic [95:0] data;
        logic [2:0]  e_ready;
        logic        e_stall;
        logic        chk_wr;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [31:0] e_busy;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic iv, input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [2:0] valid,
        input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
        input logic [2:0] er, input logic es, input logic cw, input logic ew,
        input logic [4:0] ewa, input logic [31:0] ewd, input logic [31:0] eb,
        input logic ee);
        vec_t v;
        v.rst = r; v.iv = iv; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.valid = valid;
        v.addr = {a2, a1, a0}; v.data = {d2, d1, d0};
        v.e_ready = er; v.e_stall = es; v.chk_wr = cw; v.e_we = ew;
        v.e_waddr = ewa; v.e_wdata = ewd; v.e_busy = eb; v.e_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] valid, input logic [14:0] addr,
                         input logic [95:0] data);
        rst           = r;
        bus.iss_valid = iv;
        bus.iss_rd    = rd;
        bus.iss_rs1   = rs1;
        bus.iss_rs2   = rs2;
        bus.req_valid = valid;
        bus.req_addr  = addr;
        bus.req_data  = data;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 15'd0, 96'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 15'd0, 96'd0);
        tick();
        tick();

        //         rst iv rd rs1 rs2 valid a0 a1 a2 d0 d1 d2 | ready stall cw we waddr wdata busy err
        vecs.push_back(mk(1,1,1,0,0,3'b111,1,2,3,32'h11,32'h22,32'h33, 3'b000,0,1,0,0,32'h0,32'h0,0));
        vecs.push_back(mk(0,0,0,0,0,3'b000,0,0,0,0,0,0,               3'b000,0,1,0,0,32'h0,32'h0,0));
        vecs.push_back(mk(0,1,5,0,0,3'b000,0,0,0,0,0,0,               3'b000,0,1,0,0,32'h0,32'h20,0));
        vecs.push_back(mk(0,0,0,0,0,3'b010,0,5,0,32'h1,32'hDEADBEEF,32'h2, 3'b010,0,1,1,5,32'hDEADBEEF,32'h0,0));
        vecs.push_back(mk(0,0,0,0,0,3'b000,0,0,0,0,0,0,               3'b000,0,1,0,5,32'hDEADBEEF,32'h0,0));
        vecs.push_back(mk(0,1,7,0,0,3'b000,0,0,0,0,0,0,               3'b000,0,1,0,5,32'hDEADBEEF,32'h80,0));
        vecs.push_back(mk(0,1,8,7,0,3'b000,0,0,0,0,0,0,               3'b000,1,1,0,5,32'hDEADBEEF,32'h80,0));
        vecs.push_back(mk(0,1,8,7,0,3'b001,7,0,0,32'h7777,0,0,        3'b001,1,1,1,7,32'h7777,32'h0,0));
        vecs.push_back(mk(0,1,8,7,0,3'b000,0,0,0,0,0,0,               3'b000,0,1,0,7,32'h7777,32'h100,0));
        vecs.push_back(mk(0,0,0,0,0,3'b100,0,0,0,0,0,32'hAAAA,        3'b100,0,0,0,0,32'h0,32'h100,0));
        vecs.push_back(mk(0,0,0,0,0,3'b010,0,8,0,0,32'h8888,0,        3'b010,0,1,1,8,32'h8888,32'h0,0));
        vecs.push_back(mk(0,0,0,0,0,3'b001,3,0,0,32'h3333,0,0,        3'b001,0,1,1,3,32'h3333,32'h0,1));
        vecs.push_back(mk(0,1,9,0,0,3'b100,0,0,9,0,0,32'h9999,        3'b100,0,1,1,9,32'h9999,32'h200,1));
        vecs.push_back(mk(0,0,0,9,0,3'b000,0,0,0,0,0,0,               3'b000,0,1,0,9,32'h9999,32'h200,1));
        vecs.push_back(mk(0,1,9,0,0,3'b000,0,0,0,0,0,0,               3'b000,1,1,0,9,32'h9999,32'h200,1));
        vecs.push_back(mk(0,1,0,0,9,3'b000,0,0,0,0,0,0,               3'b000,1,1,0,9,32'h9999,32'h200,1));
        vecs.push_back(mk(0,1,0,0,0,3'b000,0,0,0,0,0,0,               3'b000,0,1,0,9,32'h9999,32'h200,1));
        vecs.push_back(mk(0,0,0,0,0,3'b110,0,9,4,0,32'h5A5A,32'h4444, 3'b010,0,1,1,9,32'h5A5A,32'h0,1));
        vecs.push_back(mk(0,0,0,0,0,3'b101,4,0,4,32'h4444,0,32'h2222, 3'b100,0,1,1,4,32'h2222,32'h0,1));
        vecs.push_back(mk(0,0,0,0,0,3'b101,4,0,4,32'h4444,0,32'h2222, 3'b001,0,1,1,4,32'h4444,32'h0,1));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].valid, vecs[i].addr, vecs[i].data);
            #1;
            check($sformatf("v%0d ready", i), 64'(bus.req_ready), 64'(vecs[i].e_ready));
            check($sformatf("v%0d stall", i), 64'(bus.iss_stall), 64'(vecs[i].e_stall));
            tick();
            check($sformatf("v%0d rf_we", i), 64'(bus.rf_we), 64'(vecs[i].e_we));
            if (vecs[i].chk_wr) begin
                check($sformatf("v%0d rf_waddr", i), 64'(bus.rf_waddr), 64'(vecs[i].e_waddr));
                check($sformatf("v%0d rf_wdata", i), 64'(bus.rf_wdata), 64'(vecs[i].e_wdata));
            end
            check($sformatf("v%0d busy_vec", i), 64'(bus.busy_vec), 64'(vecs[i].e_busy));
            check($sformatf("v%0d wb_err", i), 64'(bus.wb_err), 64'(vecs[i].e_err));
        end

        // Reset clears the sticky error and restarts the pointer at requester 0.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 15'd0, 96'd0);
        tick();
        check("rst wb_err", 64'(bus.wb_err), 64'd0);
        check("rst rf_we", 64'(bus.rf_we), 64'd0);

        // Round-robin with all three requesters held valid.
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b111, {5'd12, 5'd11, 5'd10},
              {32'hC2C2, 32'hB1B1, 32'hA0A0});
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("rr%0d ready", k), 64'(bus.req_ready), 64'(3'b001 << (k % 3)));
            tick();
            check($sformatf("rr%0d rf_we", k), 64'(bus.rf_we), 64'd1);
            check($sformatf("rr%0d rf_waddr", k), 64'(bus.rf_waddr), 64'(10 + (k % 3)));
        end

        // Reset in the middle of outstanding work.
        drive(1'b0, 1'b1, 5'd7, 5'd0, 5'd0, 3'b000, 15'd0, 96'd0);
        tick();
        drive(1'b0, 1'b1, 5'd10, 5'd0, 5'd0, 3'b000, 15'd0, 96'd0);
        tick();
        check("mid busy", 64'(bus.busy_vec), 64'h480);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b001, {5'd0, 5'd0, 5'd7}, {64'd0, 32'h7070});
        #1;
        check("mid ready", 64'(bus.req_ready), 64'(3'b001));
        tick();
        check("mid rf_we", 64'(bus.rf_we), 64'd1);
        drive(1'b1, 1'b1, 5'd0, 5'd10, 5'd0, 3'b111, {5'd12, 5'd11, 5'd10}, 96'd0);
        #1;
        check("inrst ready", 64'(bus.req_ready), 64'd0);
        check("inrst stall", 64'(bus.iss_stall), 64'd0);
        tick();
        check("postrst busy", 64'(bus.busy_vec), 64'd0);
        check("postrst rf_we", 64'(bus.rf_we), 64'd0);
        check("postrst rf_waddr", 64'(bus.rf_waddr), 64'd0);
        check("postrst rf_wdata", 64'(bus.rf_wdata), 64'd0);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b111, {5'd12, 5'd11, 5'd10}, 96'd0);
        #1;
        check("postrst rr_ptr", 64'(bus.req_ready), 64'(3'b001));
        tick();
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
